adc_ring_writer: RTL

Sequencer between the dual-channel ADC capture stage (EMG/ECG) and the data RAM's dedicated ADC write port. It generates the fixed-rate sample tick and latches one EMG/ECG sample pair per tick. It writes the pair as two consecutive RAM writes into two per-channel ring buffers, using a req/gnt handshake. The processor reads the ring buffers and polls sample_idx/overrun to find fresh data.

---
 rtl/adc_pkg.sv | 20 ++
 rtl/adc_sample_timer.sv | 30 +++
 rtl/adc_ring_writer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared ADC ring writer state encoding and memory-map defaults
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_VALID = 2'd1,
    WR_EMG     = 2'd2,
    WR_ECG     = 2'd3
  } adc_state_e;

  // Shared by the wrapper memory map and processor software headers
  localparam int ADC_SAMPLE_INTERVAL = 175000;
  localparam int ADC_DEPTH           = 800;
  localparam int ADC_EMG_BASE        = 'h400;
  localparam int ADC_ECG_BASE        = 'h800;
  localparam int ADC_ADDR_W          = 12;
  localparam int ADC_DATA_W          = 32;
  localparam int ADC_IDX_W           = 10;

endpackage

// File: rtl/adc_sample_timer.sv
// rtl/adc_sample_timer.sv - free-running sample tick generator
module adc_sample_timer
  import adc_pkg::*;
#(
  parameter int SAMPLE_INTERVAL = ADC_SAMPLE_INTERVAL
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_INTERVAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_ring_writer.sv
// rtl/adc_ring_writer.sv - writes one EMG/ECG pair per tick into two RAM ring buffers
module adc_ring_writer
  import adc_pkg::*;
#(
  parameter int SAMPLE_INTERVAL = ADC_SAMPLE_INTERVAL,
  parameter int DEPTH           = ADC_DEPTH,
  parameter int EMG_BASE        = ADC_EMG_BASE,
  parameter int ECG_BASE        = ADC_ECG_BASE,
  parameter int ADDR_W          = ADC_ADDR_W,
  parameter int DATA_W          = ADC_DATA_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    emg_in,
  input  logic [DATA_W-1:0]    ecg_in,
  input  logic                 adc_valid,
  output logic                 wr_req,
  input  logic                 wr_gnt,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic [ADC_IDX_W-1:0] sample_idx,
  output logic                 pair_valid,
  output logic                 overrun,
  input  logic                 clear_overrun
);

  localparam logic [ADDR_W-1:0]    EMG_BASE_A = ADDR_W'(EMG_BASE);
  localparam logic [ADDR_W-1:0]    ECG_BASE_A = ADDR_W'(ECG_BASE);
  localparam logic [ADC_IDX_W-1:0] IDX_LAST   = ADC_IDX_W'(DEPTH - 1);

  logic tick;

  adc_state_e           state_q, state_d;
  logic [ADC_IDX_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]    ecg_q, ecg_d;
  logic                 wr_req_q, wr_req_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]    wr_data_q, wr_data_d;
  logic [ADC_IDX_W-1:0] sample_idx_q, sample_idx_d;
  logic                 pair_valid_q, pair_valid_d;
  logic                 overrun_q, overrun_d;

  adc_sample_timer #(
    .SAMPLE_INTERVAL(SAMPLE_INTERVAL)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ecg_d        = ecg_q;
    wr_req_d     = wr_req_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    sample_idx_d = sample_idx_q;
    pair_valid_d = pair_valid_q;
    overrun_d    = overrun_q;

    unique case (state_q)
      IDLE, WAIT_VALID: begin
        if ((state_q == WAIT_VALID) || tick) begin
          if (adc_valid) begin
            // The EMG sample lives in wr_data_q until its write is granted
            ecg_d     = ecg_in;
            wr_req_d  = 1'b1;
            wr_addr_d = EMG_BASE_A + ADDR_W'(idx_q);
            wr_data_d = emg_in;
            state_d   = WR_EMG;
          end else begin
            state_d   = WAIT_VALID;
          end
        end
      end
      WR_EMG: begin
        if (wr_gnt) begin
          wr_addr_d = ECG_BASE_A + ADDR_W'(idx_q);
          wr_data_d = ecg_q;
          state_d   = WR_ECG;
        end
      end
      WR_ECG: begin
        if (wr_gnt) begin
          wr_req_d     = 1'b0;
          sample_idx_d = idx_q;
          pair_valid_d = 1'b1;
          idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        wr_req_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    // A dropped tick outranks a simultaneous clear so it is never lost
    if (tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      ecg_q        <= '0;
      wr_req_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      sample_idx_q <= '0;
      pair_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ecg_q        <= ecg_d;
      wr_req_q     <= wr_req_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      sample_idx_q <= sample_idx_d;
      pair_valid_q <= pair_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign wr_req     = wr_req_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign sample_idx = sample_idx_q;
  assign pair_valid = pair_valid_q;
  assign overrun    = overrun_q;

endmodule
